// File: rtl/loom_dpi_responder.sv
// loom_dpi_responder: host-facing end of the DPI call path; forwards one call at a time
// to the host, collects the return value (or times out) and hands it back to the caller.
module loom_dpi_responder #(
   parameter int FUNC_ID_W   = 8,
   parameter int N_ARGS      = 4,
   parameter int ARG_W       = 32,
   parameter int RET_W       = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      call_valid_i,
   output logic                      call_ready_o,
   input  logic [FUNC_ID_W-1:0]      call_func_id_i,
   input  logic [N_ARGS*ARG_W-1:0]   call_args_i,
   input  logic                      call_has_ret_i,
   output logic                      ret_valid_o,
   input  logic                      ret_ready_i,
   output logic [RET_W-1:0]          ret_data_o,
   output logic                      host_req_valid_o,
   output logic [FUNC_ID_W-1:0]      host_req_func_id_o,
   output logic [N_ARGS*ARG_W-1:0]   host_req_args_o,
   input  logic                      host_req_ack_i,
   input  logic                      host_ret_valid_i,
   input  logic [RET_W-1:0]          host_ret_data_i,
   output logic                      stall_o,
   output logic                      timeout_o,
   output logic [15:0]               call_count_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RET, RESPOND} state_t;
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   state_t                    state;
   logic                      has_ret_q;
   logic [FUNC_ID_W-1:0]      func_id_q;
   logic [N_ARGS*ARG_W-1:0]   args_q;
   logic [RET_W-1:0]          ret_q;
   logic [CNT_W-1:0]          cnt_q;
   logic                      timeout_q;
   logic [15:0]               count_q;
   logic                      timed_out;
   // A zero TIMEOUT_CYC disables the timeout; the counter then just free-runs.
   assign timed_out = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         has_ret_q <= 1'b0;
         func_id_q <= '0;
         args_q    <= '0;
         ret_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         count_q   <= '0;
      end else begin
         case (state)
            IDLE: if (call_valid_i) begin
               func_id_q <= call_func_id_i;
               args_q    <= call_args_i;
               has_ret_q <= call_has_ret_i;
               state     <= ISSUE;
            end
            ISSUE: if (host_req_ack_i) begin
               cnt_q <= '0;
               if (has_ret_q) state <= WAIT_RET;
               else begin
                  ret_q <= '0;
                  state <= RESPOND;
               end
            end
            WAIT_RET: if (host_ret_valid_i) begin
               ret_q <= host_ret_data_i;
               state <= RESPOND;
            end else if (timed_out) begin
               ret_q     <= '0;
               timeout_q <= 1'b1;
               state     <= RESPOND;
            end else cnt_q <= cnt_q + 1'b1;
            RESPOND: if (ret_ready_i) begin
               count_q <= count_q + 16'd1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign call_ready_o       = (state == IDLE);
   assign host_req_valid_o   = (state == ISSUE);
   assign ret_valid_o        = (state == RESPOND);
   assign stall_o            = (state != IDLE);
   assign ret_data_o         = ret_q;
   assign host_req_func_id_o = func_id_q;
   assign host_req_args_o    = args_q;
   assign timeout_o          = timeout_q;
   assign call_count_o       = count_q;
endmodule
